// File: rtl/pwm_capture.sv
// pwm_capture: measures an incoming PWM waveform.
// Reports high time, period and a 4-bit duty code, and flags an edge-less input.
module pwm_capture #(
    parameter int  PWM_FREQ        = 1_000,
    parameter int  CLK_FREQ        = 200_000_000,
    parameter int  TIMEOUT_PERIODS = 2,
    localparam int CNT_THRESH      = CLK_FREQ / PWM_FREQ,
    localparam int CNT_MAX         = TIMEOUT_PERIODS * CNT_THRESH,
    localparam int CNT_WIDTH       = $clog2(CNT_MAX + 1)
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic                 pwm_in,
    output logic [3:0]           duty_cycle,
    output logic [CNT_WIDTH-1:0] high_time,
    output logic [CNT_WIDTH-1:0] period,
    output logic                 meas_valid,
    output logic                 static_lvl,
    output logic                 overrun
);

    localparam logic [CNT_WIDTH-1:0] CNT_SAT = CNT_WIDTH'(CNT_MAX);

    typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_LOW} state_t;

    state_t               state;
    logic                 sync1, pwm_s, pwm_d;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] high_q;

    logic                 div_busy;
    logic [1:0]           div_step;
    logic [CNT_WIDTH:0]   div_rem;
    logic [3:0]           div_q;
    logic [CNT_WIDTH-1:0] div_high;
    logic [CNT_WIDTH-1:0] div_per;

    logic                 rise, fall, timeout_hit, closing, div_start, div_done;
    logic [CNT_WIDTH:0]   rem_sh, rem_nx;
    logic                 rem_ge;
    logic [3:0]           q_nx;

    // Edge detection, timeout detection and one restoring-division step.
    always_comb begin
        rise        = pwm_s & ~pwm_d;
        fall        = ~pwm_s & pwm_d;
        // Fires only on the clock where cnt steps onto saturation, so a static
        // input produces exactly one event until the next rise restarts cnt.
        timeout_hit = (cnt == CNT_SAT - CNT_WIDTH'(1)) && !rise;
        closing     = (state == ST_LOW) && rise;
        div_start   = closing && !div_busy;
        div_done    = div_busy && (div_step == 2'd3);
        rem_sh      = {div_rem[CNT_WIDTH-1:0], 1'b0};
        rem_ge      = (rem_sh >= {1'b0, div_per});
        rem_nx      = rem_ge ? (rem_sh - {1'b0, div_per}) : rem_sh;
        q_nx        = {div_q[2:0], rem_ge};
    end

    // Two-flop synchronizer plus one delay stage for edge detection.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            sync1 <= 1'b0;
            pwm_s <= 1'b0;
            pwm_d <= 1'b0;
        end else begin
            sync1 <= pwm_in;
            pwm_s <= sync1;
            pwm_d <= pwm_s;
        end
    end

    // Free-running interval counter, restarted by each rise, saturating.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            cnt <= '0;
        end else if (rise) begin
            cnt <= CNT_WIDTH'(1);
        end else if (cnt != CNT_SAT) begin
            cnt <= cnt + CNT_WIDTH'(1);
        end
    end

    // Measurement FSM: tracks rise-fall-rise and captures the high time.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state  <= ST_IDLE;
            high_q <= '0;
        end else if (timeout_hit) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (rise) state <= ST_HIGH;
                ST_HIGH: if (fall) begin
                    high_q <= cnt;
                    state  <= ST_LOW;
                end
                ST_LOW:  if (rise) state <= ST_HIGH;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Four-step divider; keeps its own copy of the operands so that the
    // measurement can run ahead while the quotient is being formed.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            div_busy <= 1'b0;
            div_step <= '0;
            div_rem  <= '0;
            div_q    <= '0;
            div_high <= '0;
            div_per  <= '0;
        end else if (timeout_hit) begin
            div_busy <= 1'b0;
        end else if (div_start) begin
            div_busy <= 1'b1;
            div_step <= '0;
            div_rem  <= {1'b0, high_q};
            div_q    <= '0;
            div_high <= high_q;
            div_per  <= cnt;
        end else if (div_busy) begin
            div_rem  <= rem_nx;
            div_q    <= q_nx;
            div_step <= div_step + 2'd1;
            if (div_step == 2'd3) div_busy <= 1'b0;
        end
    end

    // Output registers: publish measurements, timeout values and overrun.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            duty_cycle <= '0;
            high_time  <= '0;
            period     <= '0;
            meas_valid <= 1'b0;
            static_lvl <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            overrun    <= closing && div_busy;
            if (timeout_hit) begin
                static_lvl <= 1'b1;
                high_time  <= '0;
                period     <= '0;
                duty_cycle <= pwm_s ? 4'hF : 4'h0;
                meas_valid <= 1'b1;
            end else if (div_done) begin
                static_lvl <= 1'b0;
                high_time  <= div_high;
                period     <= div_per;
                duty_cycle <= q_nx;
                meas_valid <= 1'b1;
            end
        end
    end

endmodule
